mem_access_stage: RTL

- Memory-access pipeline stage that sits between the execute/memory pipeline register and memwb_reg.
- Turns load/store micro-ops into word-aligned data-bus transactions using a req/ack handshake.
- Stalls the pipeline while a transaction is outstanding.
- Presents the memwb_reg input bundle: wa, wreg, dreg, mreg, dre, sign, whilo, hilo. Byte/half extraction happens in write-back.

---
 rtl/mem_access_stage.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: turns load/store micro-ops into word-aligned req/ack bus cycles.
// Define MEM_TIMEOUT_EN to add a bus watchdog (TIMEOUT_CYCLES) and the bus_err output.
`timescale 1ns/1ps
module mem_access_stage
   #(parameter int TIMEOUT_CYCLES = 255)
(
   input  logic        cpu_clk_50M,
   input  logic        cpu_rst,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_sdata,
   input  logic [4:0]  mem_wa,
   input  logic        mem_wreg,
   input  logic [31:0] mem_alu_res,
   input  logic        mem_whilo,
   input  logic [63:0] mem_hilo,
   output logic        mem_stall,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic [4:0]  out_wa,
   output logic        out_wreg,
   output logic [31:0] out_dreg,
   output logic        out_mreg,
   output logic [3:0]  out_dre,
   output logic        out_sign,
   output logic        out_whilo,
   output logic [63:0] out_hilo,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic [31:0] badvaddr
`ifdef MEM_TIMEOUT_EN
   , output logic      bus_err
`endif
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

   state_t      state, state_nx;
   logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
   logic        misaligned, start;
   logic [3:0]  lane_be;
   logic [31:0] store_data;
   logic [31:0] rdata_q;
   logic        sign_q;
   logic        timed_out;
   logic        done_err;

   // Decode the micro-op into load/store class, access size and signedness
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_signed = 1'b0;
      case (mem_op)
         OP_LB:   begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
         OP_LBU:  begin is_load = 1'b1; is_byte = 1'b1; end
         OP_LH:   begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
         OP_LHU:  begin is_load = 1'b1; is_half = 1'b1; end
         OP_LW:   is_load = 1'b1;
         OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
         OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
         OP_SW:   is_store = 1'b1;
         default: ;
      endcase
   end

   assign is_word    = (is_load | is_store) & ~is_byte & ~is_half;
   assign misaligned = (is_half & mem_addr[0]) | (is_word & (|mem_addr[1:0]));
   assign start      = mem_valid & (is_load | is_store) & ~misaligned & ~flush;

   // Little-endian lane selection and store-data replication across the word
   always_comb begin
      if (is_byte) begin
         lane_be    = 4'b0001 << mem_addr[1:0];
         store_data = {4{mem_sdata[7:0]}};
      end else if (is_half) begin
         lane_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
         store_data = {2{mem_sdata[15:0]}};
      end else begin
         lane_be    = 4'b1111;
         store_data = mem_sdata;
      end
   end

   assign exc_adel = mem_valid & is_load & misaligned;
   assign exc_ades = mem_valid & is_store & misaligned;
   assign badvaddr = (exc_adel | exc_ades) ? mem_addr : 32'h0;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign done_err  = err_q;
   assign bus_err   = (state == DONE) & err_q;

   // Watchdog counts bus-wait cycles; err_q marks a DONE reached by abort, not by ack
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == REQ || state == DRAIN) wait_cnt <= wait_cnt + 1'b1;
         else                                wait_cnt <= '0;
         err_q <= (state == REQ) & ~dbus_ack & ~flush & timed_out;
      end
   end
`else
   assign timed_out = 1'b0;
   assign done_err  = 1'b0;
`endif

   // State register with asynchronous reset back to IDLE
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) state <= IDLE;
      else         state <= state_nx;
   end

   // Bus fields are frozen at REQ entry so they stay stable until ack
   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         dbus_we    <= 1'b0;
         dbus_addr  <= 32'h0;
         dbus_be    <= 4'h0;
         dbus_wdata <= 32'h0;
         sign_q     <= 1'b0;
         rdata_q    <= 32'h0;
      end else begin
         if (state == IDLE && start) begin
            dbus_we    <= is_store;
            dbus_addr  <= {mem_addr[31:2], 2'b00};
            dbus_be    <= lane_be;
            dbus_wdata <= store_data;
            sign_q     <= is_signed;
         end
         if (state == REQ && dbus_ack && !flush && !dbus_we) rdata_q <= dbus_rdata;
      end
   end

   // Next-state, stall and request generation; a flushed transaction still owns the bus until the slave answers
   always_comb begin
      state_nx  = state;
      mem_stall = 1'b0;
      dbus_req  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               mem_stall = 1'b1;
               state_nx  = REQ;
            end
         end
         REQ: begin
            mem_stall = 1'b1;
            dbus_req  = 1'b1;
            if (dbus_ack)       state_nx = flush ? IDLE : DONE;
            else if (flush)     state_nx = DRAIN;
            else if (timed_out) state_nx = DONE;
         end
         DRAIN: begin
            mem_stall = 1'b1;
            dbus_req  = 1'b1;
            if (dbus_ack || timed_out) state_nx = IDLE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output bundle towards memwb_reg: pass-through for non-memory ops, load result in DONE
   always_comb begin
      out_wa    = 5'h0;
      out_wreg  = 1'b0;
      out_dreg  = 32'h0;
      out_mreg  = 1'b0;
      out_dre   = 4'h0;
      out_sign  = 1'b0;
      out_whilo = 1'b0;
      out_hilo  = 64'h0;
      if (mem_valid && !flush) begin
         case (state)
            IDLE: begin
               if (!is_load && !is_store) begin
                  out_wa    = mem_wa;
                  out_wreg  = mem_wreg;
                  out_dreg  = mem_alu_res;
                  out_whilo = mem_whilo;
                  out_hilo  = mem_hilo;
               end
            end
            DONE: begin
               out_wa = mem_wa;
               if (!done_err) begin
                  out_whilo = mem_whilo;
                  out_hilo  = mem_hilo;
                  if (!dbus_we) begin
                     out_wreg = mem_wreg;
                     out_dreg = rdata_q;
                     out_mreg = 1'b1;
                     out_dre  = dbus_be;
                     out_sign = sign_q;
                  end else begin
                     out_dreg = mem_alu_res;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
